// File: rtl/dtc_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : dtc_pkg                                                         |
// | Brief    : Shared constants and decode helpers for dtc thermometer words.  |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package dtc_pkg;

  localparam int DTC_W = 12;

  function automatic int lvl_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int DTC_LW = lvl_w(DTC_W);

  // Computed one bit wider so the all-ones word does not wrap to zero on +1.
  function automatic logic therm_legal(input logic [DTC_W-1:0] d);
    logic [DTC_W:0] w_x;
    w_x = {1'b0, d};
    return ((w_x & (w_x + 1'b1)) == '0);
  endfunction

  function automatic logic [DTC_LW-1:0] popcnt(input logic [DTC_W-1:0] d);
    logic [DTC_LW-1:0] w_cnt;
    w_cnt = '0;
    for (int i = 0; i < DTC_W; i++) begin
      w_cnt = w_cnt + {{(DTC_LW-1){1'b0}}, d[i]};
    end
    return w_cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dtc_win_acc.sv
// +----------------------------------------------------------------------------+
// | Module   : dtc_win_acc                                                     |
// | Brief    : Windowed level accumulator with sticky error over WIN samples.  |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module dtc_win_acc
  import dtc_pkg::*;
#(
  parameter int LW  = 4,
  parameter int WIN = 8,
  parameter int SW  = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          xfer,
  input  logic [LW-1:0] level,
  input  logic          err,
  output logic          win_valid,
  output logic [SW-1:0] win_sum,
  output logic          win_err
);

  localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIN - 1);

  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_acc;
  logic          r_acc_err;
  logic [SW-1:0] w_level_ext;
  logic          r_win_valid;
  logic [SW-1:0] r_win_sum;
  logic          r_win_err;

  assign w_level_ext = {{(SW-LW){1'b0}}, level};

  // The closing sample folds straight into the result, so the next window
  // starts from zero on the following transfer without any gap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_acc       <= '0;
      r_acc_err   <= 1'b0;
      r_win_valid <= 1'b0;
      r_win_sum   <= '0;
      r_win_err   <= 1'b0;
    end else begin
      r_win_valid <= 1'b0;
      if (xfer) begin
        if (r_cnt == C_LAST) begin
          r_win_sum   <= r_acc + w_level_ext;
          r_win_err   <= r_acc_err | err;
          r_win_valid <= 1'b1;
          r_acc       <= '0;
          r_acc_err   <= 1'b0;
          r_cnt       <= '0;
        end else begin
          r_acc     <= r_acc + w_level_ext;
          r_acc_err <= r_acc_err | err;
          r_cnt     <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign win_valid = r_win_valid;
  assign win_sum   = r_win_sum;
  assign win_err   = r_win_err;

endmodule

`default_nettype wire

// File: rtl/dtc_therm_decoder.sv
// +----------------------------------------------------------------------------+
// | Module   : dtc_therm_decoder                                               |
// | Brief    : Thermometer-word decoder with windowed sum; optional error      |
// |            counter port when DTC_ERR_CNT_EN is defined.                    |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module dtc_therm_decoder
  import dtc_pkg::*;
#(
  parameter int W   = DTC_W,
  parameter int LW  = lvl_w(W),
  parameter int WIN = 8,
  parameter int SW  = $clog2(WIN * W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  input  logic [W-1:0]  s_data,
  output logic          s_ready,
  output logic          m_valid,
  output logic [LW-1:0] m_level,
  output logic          m_err,
  input  logic          m_ready,
  output logic          win_valid,
  output logic [SW-1:0] win_sum,
  output logic          win_err
`ifdef DTC_ERR_CNT_EN
  ,
  output logic [15:0]   err_cnt
`endif
);

  logic          r_m_valid;
  logic [LW-1:0] r_m_level;
  logic          r_m_err;
  logic          w_in_xfer;
  logic          w_out_xfer;
  logic [LW-1:0] w_level;
  logic          w_illegal;

  assign w_level    = LW'(popcnt(s_data));
  assign w_illegal  = !therm_legal(s_data);
  assign s_ready    = !r_m_valid || m_ready;
  assign w_in_xfer  = s_valid && s_ready;
  assign w_out_xfer = r_m_valid && m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_level <= '0;
      r_m_err   <= 1'b0;
    end else if (w_in_xfer) begin
      r_m_valid <= 1'b1;
      r_m_level <= w_level;
      r_m_err   <= w_illegal;
    end else if (w_out_xfer) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_valid = r_m_valid;
  assign m_level = r_m_level;
  assign m_err   = r_m_err;

  dtc_win_acc #(
    .LW  (LW),
    .WIN (WIN),
    .SW  (SW)
  ) u_win_acc (
    .clk       (clk),
    .rst       (rst),
    .xfer      (w_out_xfer),
    .level     (r_m_level),
    .err       (r_m_err),
    .win_valid (win_valid),
    .win_sum   (win_sum),
    .win_err   (win_err)
  );

`ifdef DTC_ERR_CNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_out_xfer && r_m_err && (r_err_cnt != 16'hFFFF)) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dtc_therm_decoder.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_dtc_therm_decoder                                            |
// | Brief    : Directed self-checking bench for dtc_therm_decoder.             |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dtc_therm_decoder;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic [11:0] s_data;
  logic        s_ready;
  logic        m_valid;
  logic [3:0]  m_level;
  logic        m_err;
  logic        m_ready;
  logic        win_valid;
  logic [6:0]  win_sum;
  logic        win_err;
`ifdef DTC_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [11:0] words [0:15];
  int          pulses;
  logic [6:0]  p_sum [0:3];
  logic        p_err [0:3];

  dtc_therm_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .m_valid   (m_valid),
    .m_level   (m_level),
    .m_err     (m_err),
    .m_ready   (m_ready),
    .win_valid (win_valid),
    .win_sum   (win_sum),
    .win_err   (win_err)
`ifdef DTC_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    s_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Streams words[0..n-1] back to back, then idles; records window pulses.
  task automatic run_stream(input int n, input int extra);
    pulses = 0;
    for (int i = 0; i < n + extra; i++) begin
      if (i < n) begin
        s_valid = 1'b1;
        s_data  = words[i];
      end else begin
        s_valid = 1'b0;
      end
      step();
      if (win_valid) begin
        if (pulses < 4) begin
          p_sum[pulses] = win_sum;
          p_err[pulses] = win_err;
        end
        pulses++;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; s_valid = 1'b1; s_data = 12'h03F; m_ready = 1'b1;
    step();
    step();
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready);
    end
    checks++;
    if ({m_valid, m_level, m_err} !== 6'b0) begin
      errors++; $display("FAIL reset_m: got v=%b l=%0d e=%b want 0/0/0", m_valid, m_level, m_err);
    end
    checks++;
    if ({win_valid, win_sum, win_err} !== 9'b0) begin
      errors++; $display("FAIL reset_win: got v=%b s=%0d e=%b want 0/0/0", win_valid, win_sum, win_err);
    end
`ifdef DTC_ERR_CNT_EN
    checks++;
    if (err_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
    end
`endif
    rst = 1'b0; s_valid = 1'b0;
  endtask

  task automatic test_decode;
    logic [11:0] vw [0:5];
    logic [3:0]  vl [0:5];
    logic        ve [0:5];
    vw[0] = 12'b000000111111; vl[0] = 4'd6;  ve[0] = 1'b0;
    vw[1] = 12'b000001011111; vl[1] = 4'd6;  ve[1] = 1'b1;
    vw[2] = 12'h000;          vl[2] = 4'd0;  ve[2] = 1'b0;
    vw[3] = 12'hFFF;          vl[3] = 4'd12; ve[3] = 1'b0;
    vw[4] = 12'h800;          vl[4] = 4'd1;  ve[4] = 1'b1;
    vw[5] = 12'h001;          vl[5] = 4'd1;  ve[5] = 1'b0;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data  = vw[i];
      step();
      s_valid = 1'b0;
      checks++;
      if (m_valid !== 1'b1 || m_level !== vl[i] || m_err !== ve[i]) begin
        errors++;
        $display("FAIL decode[%0d] %h: got v=%b l=%0d e=%b want 1/%0d/%b",
                 i, vw[i], m_valid, m_level, m_err, vl[i], ve[i]);
      end
    end
    step();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL decode_drain: m_valid got %b want 0", m_valid);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 12'h007;
    step();
    s_data = 12'h00F;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_level !== 4'd3 || m_err !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rdy=%b v=%b l=%0d e=%b want 0/1/3/0",
                 i, s_ready, m_valid, m_level, m_err);
      end
      step();
    end
    m_ready = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b want 1", s_ready);
    end
    step();
    checks++;
    if (m_valid !== 1'b1 || m_level !== 4'd4) begin
      errors++; $display("FAIL bp_b: got v=%b l=%0d want 1/4", m_valid, m_level);
    end
    s_data = 12'h01F;
    step();
    checks++;
    if (m_valid !== 1'b1 || m_level !== 4'd5) begin
      errors++; $display("FAIL bp_c: got v=%b l=%0d want 1/5", m_valid, m_level);
    end
    s_valid = 1'b0;
    step();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: m_valid got %b want 0", m_valid);
    end
  endtask

  task automatic test_back_to_back_windows;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) words[i] = 12'h01F;
    for (int i = 8; i < 16; i++) words[i] = 12'h003;
    words[11] = 12'h05F;
    run_stream(16, 4);
    checks++;
    if (pulses !== 2) begin
      errors++; $display("FAIL b2b_pulses: got %0d want 2", pulses);
    end
    checks++;
    if (p_sum[0] !== 7'd40 || p_err[0] !== 1'b0) begin
      errors++; $display("FAIL clean_window: got sum=%0d err=%b want 40/0", p_sum[0], p_err[0]);
    end
    checks++;
    if (p_sum[1] !== 7'd20 || p_err[1] !== 1'b1) begin
      errors++; $display("FAIL bad_window: got sum=%0d err=%b want 20/1", p_sum[1], p_err[1]);
    end
    step();
    checks++;
    if (win_valid !== 1'b0 || win_sum !== 7'd20 || win_err !== 1'b1) begin
      errors++; $display("FAIL win_hold: got v=%b sum=%0d err=%b want 0/20/1", win_valid, win_sum, win_err);
    end
  endtask

  task automatic test_reset_mid_window;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) words[i] = 12'h07F;
    words[2] = 12'h0BF;
    run_stream(5, 2);
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL partial_no_pulse: got %0d pulses want 0", pulses);
    end
`ifdef DTC_ERR_CNT_EN
    checks++;
    if (err_cnt !== 16'd1) begin
      errors++; $display("FAIL err_cnt_count: got %0d want 1", err_cnt);
    end
`endif
    do_reset();
`ifdef DTC_ERR_CNT_EN
    checks++;
    if (err_cnt !== 16'd0) begin
      errors++; $display("FAIL err_cnt_reset: got %0d want 0", err_cnt);
    end
`endif
    for (int i = 0; i < 8; i++) words[i] = 12'h001;
    run_stream(8, 3);
    checks++;
    if (pulses !== 1 || p_sum[0] !== 7'd8 || p_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_window: got pulses=%0d sum=%0d err=%b want 1/8/0",
               pulses, p_sum[0], p_err[0]);
    end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    test_reset();
    test_decode();
    test_backpressure();
    test_back_to_back_windows();
    test_reset_mid_window();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dtc_therm_decoder.md
# dtc_therm_decoder

Streaming decoder for the 12-bit thermometer-coded score words produced by the `dtc_*` decision-tree classifiers. It sits on the classifier output side. For each word it:
- checks that the code is legal,
- converts it to a binary level,
- flags malformed words,
- accumulates levels over a fixed window for downstream thresholding.

It provides a valid/ready handshake, so a registered classifier wrapper can stream into it under backpressure.

## Interface
- `W`, 12: thermometer word width.
- `LW`, 4: level width, equal to `$clog2(W+1)`.
- `WIN`, 8: samples per accumulation window; must be ≥2.
- `SW`, 7: window-sum width, equal to `$clog2(WIN*W+1)`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: input word valid.
- `s_data` in W: thermometer word; ones fill from bit 0 upward.
- `s_ready` out 1: decoder can accept a word.
- `m_valid` out 1: decoded sample valid.
- `m_level` out LW: number of ones in the accepted word.
- `m_err` out 1: accepted word was not a legal thermometer code.
- `m_ready` in 1: downstream accepts the sample.
- `win_valid` out 1: one-cycle pulse; window result available.
- `win_sum` out SW: sum of `m_level` over the last WIN delivered samples.
- `win_err` out 1: at least one sample in that window had `m_err` set.

## Operation
- **Legal code:** `s_data == (1<<k)-1` for k in 0..W. Check: `(s_data & (s_data+1)) == 0`, evaluated at width W+1.
- **Level:** always the popcount of `s_data`. A legal word therefore gives k. An illegal word still gives its popcount, with `m_err=1`.
- **Input acceptance:** a transfer occurs when `s_valid && s_ready`. The decoded level, error flag and valid are registered into the output stage.
- **Output stage:** single register with `s_ready = !m_valid || m_ready`. This pass-through-ready form gives full throughput with no bubble.
- **Output hold:** `m_level`/`m_err` hold stable while `m_valid && !m_ready`.
- **Window counter:** `cnt` runs 0..WIN-1 and advances only on output transfers (`m_valid && m_ready`). Each transfer adds `m_level` to `acc` and ORs `m_err` into `acc_err`.
- **Window close:** on the transfer where `cnt == WIN-1`:
  - `win_sum` ← `acc + m_level`; `win_err` ← `acc_err | m_err`; `win_valid` pulses next cycle.
  - `acc`, `acc_err` and `cnt` clear in the same cycle. There is no gap between windows.
- **Window outputs:** `win_sum` and `win_err` hold until the next window close. `win_valid` has no handshake; downstream must sample it on the pulse.
- **Overflow:** `acc` cannot overflow; SW covers WIN*W.

## Timing
- **Latency:** 1 cycle, from input transfer to `m_valid`.
- **Window latency:** `win_valid` asserts 1 cycle after the closing output transfer.
- **Reset values:** `m_valid=0`, `m_level=0`, `m_err=0`, `win_valid=0`, `win_sum=0`, `win_err=0`. Internal state also clears: `cnt=0`, `acc=0`, `acc_err=0`.
- **`s_ready` in reset:** `s_ready` evaluates to 1 while `rst` is high, but no transfer is taken during a reset cycle.
- **Reset mid-window:** the partial window is discarded and no `win_valid` is emitted. Counting restarts at the first transfer after reset.
- **Simultaneous in/out:** an output transfer and a new input transfer in the same cycle are legal. The new sample replaces the old one and `m_valid` stays 1.
- **Window close with new input:** the closing transfer and a new input may coincide. The new sample belongs to the next window.

## Configuration
- **`DTC_ERR_CNT_EN`:**
  - **Defined:** adds output `err_cnt` [15:0]. It counts output transfers with `m_err=1`, saturates at 16'hFFFF, and resets to 0.
  - **Undefined:** the port and counter are absent. All other behaviour is identical.

## Structure
- **Shared package `dtc_pkg`:**
  - `DTC_W=12` and the level-width function `lvl_w(w)`.
  - Function `therm_legal(logic [W-1:0])`.
  - Function `popcnt` (loop-based, synthesizable).
- **Sub-module:** one, `dtc_win_acc`. It holds `cnt`, `acc`, `acc_err` and the window outputs, and is driven by the transfer strobe plus level/err. The top level holds the decode and the output register.

## Test plan
- **Reset and legal word:** reset, then send `12'b000000111111` with `m_ready=1` → next cycle `m_valid=1`, `m_level=6`, `m_err=0`.
- **Illegal word:** send `12'b000001011111` → `m_level=6`, `m_err=1`. Send 0 → `m_level=0`, `m_err=0`. Send `12'hFFF` → `m_level=12`, `m_err=0`.
- **Backpressure:** hold `m_ready=0` for 3 cycles with `s_valid=1` → `s_ready=0` and the output is stable. Release → one word delivered per cycle, with no loss or duplication.
- **Clean window:** stream 8 words of level 5, `m_ready=1` → single `win_valid` pulse with `win_sum=40`, `win_err=0`. The next window starts with no gap.
- **Window with one bad word:** include one illegal word within the 8 → `win_err=1`, and `win_sum` includes that word's popcount.
- **Reset mid-window:** assert `rst` after 5 words, then send 8 words of level 1 → `win_sum=8`. With `DTC_ERR_CNT_EN` defined, `err_cnt` returns to 0 on reset.
